// File: rtl/if_fetch_unit_if.sv
// Instruction-memory request/response bus between the fetch unit (master) and imem (slave).
interface if_fetch_unit_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              imem_req;
  logic [ADDR_W-1:0] imem_addr;
  logic              imem_rdy;
  logic [DATA_W-1:0] imem_rdata;

  modport master (output imem_req, output imem_addr, input imem_rdy, input imem_rdata);
  modport slave  (input imem_req, input imem_addr, output imem_rdy, output imem_rdata);
endinterface

// File: rtl/if_fetch_unit.sv
// Instruction fetch producer for the IF/ID register: owns the PC, requests imem every
// cycle it has room, and presents {pc_out, instr_out, valid_out} honouring freeze.
//
// state | meaning
// ------+-------------------------------------------------------------
// BOOT  | single idle cycle after reset release, no fetch request
// RUN   | steady-state fetching; left only through reset
module if_fetch_unit #(
  parameter int              ADDR_W   = 32,
  parameter int              DATA_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter int              PC_STEP  = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                freeze,
  input  logic                branch_taken,
  input  logic [ADDR_W-1:0]   branch_addr,
  if_fetch_unit_if.master     imem,
  output logic [ADDR_W-1:0]   pc_out,
  output logic [DATA_W-1:0]   instr_out,
  output logic                valid_out,
  output logic [15:0]         stall_cnt
);

  typedef enum logic {S_BOOT = 1'b0, S_RUN = 1'b1} state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   pc_q, pc_d;
  logic [ADDR_W-1:0]   pc_out_q, pc_out_d;
  logic [DATA_W-1:0]   instr_q, instr_d;
  logic                valid_q, valid_d;
  logic [15:0]         stall_q, stall_d;
  logic                req;
  logic                xfer;
  logic [ADDR_W-1:0]   pc_next;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= S_BOOT;
      pc_q     <= RESET_PC;
      pc_out_q <= '0;
      instr_q  <= '0;
      valid_q  <= 1'b0;
      stall_q  <= '0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      pc_out_q <= pc_out_d;
      instr_q  <= instr_d;
      valid_q  <= valid_d;
      stall_q  <= stall_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    pc_out_d = pc_out_q;
    instr_d  = instr_q;
    valid_d  = valid_q;
    stall_d  = stall_q;
    pc_next  = pc_q + ADDR_W'(PC_STEP);

    case (state_q)
      S_BOOT:  state_d = S_RUN;
      S_RUN:   state_d = S_RUN;
      default: state_d = S_BOOT;
    endcase

    // A held (frozen, valid) instruction blocks the request so it is never overwritten.
    req  = (state_q == S_RUN) && !branch_taken && (!valid_q || !freeze);
    xfer = req && imem.imem_rdy;

    if (branch_taken) begin
      pc_d     = branch_addr;
      pc_out_d = '0;
      instr_d  = '0;
      valid_d  = 1'b0;
    end else if (xfer) begin
      pc_d     = pc_next;
      pc_out_d = pc_next;
      instr_d  = imem.imem_rdata;
      valid_d  = 1'b1;
    end else if (!freeze) begin
      pc_out_d = '0;
      instr_d  = '0;
      valid_d  = 1'b0;
    end

    if (req && !imem.imem_rdy && (stall_q != 16'hFFFF)) begin
      stall_d = stall_q + 16'd1;
    end
  end

  assign imem.imem_req  = req;
  assign imem.imem_addr = pc_q;
  assign pc_out         = pc_out_q;
  assign instr_out      = instr_q;
  assign valid_out      = valid_q;
  assign stall_cnt      = stall_q;

endmodule

// File: tb/tb_if_fetch_unit.sv
// Self-checking bench for if_fetch_unit: cycle reference model feeding a scoreboard
// of expected {pc_out, instr_out} pairs, plus directed checks of the key scenarios.
module tb_if_fetch_unit;

  logic        clk;
  logic        rst;
  logic        freeze;
  logic        branch_taken;
  logic [31:0] branch_addr;
  logic [31:0] pc_out;
  logic [31:0] instr_out;
  logic        valid_out;
  logic [15:0] stall_cnt;

  if_fetch_unit_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  if_fetch_unit #(.ADDR_W(32), .DATA_W(32), .RESET_PC(32'h0), .PC_STEP(4)) dut (
    .clk          (clk),
    .rst          (rst),
    .freeze       (freeze),
    .branch_taken (branch_taken),
    .branch_addr  (branch_addr),
    .imem         (bus.master),
    .pc_out       (pc_out),
    .instr_out    (instr_out),
    .valid_out    (valid_out),
    .stall_cnt    (stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] word(input logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h1357_9BDF;
  endfunction

  // Memory returns an address-derived word for whatever is being requested.
  assign bus.imem_rdata = word(bus.imem_addr);

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Reference model state
  logic        m_run;
  logic [31:0] m_pc, m_pout, m_instr;
  logic        m_valid;
  logic [15:0] m_stall;
  logic [63:0] sb[$];

  task automatic model_reset();
    m_run = 0; m_pc = 0; m_pout = 0; m_instr = 0; m_valid = 0; m_stall = 0;
    sb.delete();
  endtask

  // One clock cycle: drive at negedge, check request, advance model at posedge, check outputs.
  task automatic cyc(input logic fz, input logic br, input logic [31:0] ba, input logic rdy);
    logic        mreq;
    logic        mx;
    logic [63:0] e;
    freeze = fz; branch_taken = br; branch_addr = ba; bus.imem_rdy = rdy;
    #1;
    mreq = m_run && !br && (!m_valid || !fz);
    chk("imem_req", 64'(bus.imem_req), 64'(mreq));
    chk("imem_addr", 64'(bus.imem_addr), 64'(m_pc));
    @(posedge clk);
    mx = 0;
    if (mreq && !rdy && m_stall != 16'hFFFF) m_stall = m_stall + 16'd1;
    if (br) begin
      m_pc = ba; m_pout = 0; m_instr = 0; m_valid = 0;
    end else if (mreq && rdy) begin
      sb.push_back({m_pc + 32'd4, word(m_pc)});
      m_pc = m_pc + 32'd4; m_pout = m_pc; m_instr = word(m_pc - 32'd4); m_valid = 1; mx = 1;
    end else if (!fz) begin
      m_pout = 0; m_instr = 0; m_valid = 0;
    end
    m_run = 1;
    @(negedge clk);
    if (mx) begin
      if (sb.size() == 0) chk("sb_underflow", 64'd1, 64'd0);
      else begin
        e = sb.pop_front();
        chk("sb_pair", {pc_out, instr_out}, e);
      end
    end
    chk("valid_out", 64'(valid_out), 64'(m_valid));
    chk("pc_out", 64'(pc_out), 64'(m_pout));
    chk("instr_out", 64'(instr_out), 64'(m_instr));
    chk("stall_cnt", 64'(stall_cnt), 64'(m_stall));
  endtask

  logic [15:0] s0;

  initial begin
    rst = 0; freeze = 0; branch_taken = 0; branch_addr = 0; bus.imem_rdy = 1;
    model_reset();
    #1;
    chk("rst_req", 64'(bus.imem_req), 64'd0);
    chk("rst_pc_out", 64'(pc_out), 64'd0);
    chk("rst_valid", 64'(valid_out), 64'd0);
    chk("rst_stall", 64'(stall_cnt), 64'd0);
    @(negedge clk); @(negedge clk);
    rst = 1;

    // Boot idle cycle then streaming at addresses 0,4,8
    cyc(0, 0, 0, 1);
    chk("boot_valid", 64'(valid_out), 64'd0);
    cyc(0, 0, 0, 1);
    chk("s0", {pc_out, instr_out}, {32'd4, word(32'd0)});
    cyc(0, 0, 0, 1);
    chk("s1", {pc_out, instr_out}, {32'd8, word(32'd4)});
    cyc(0, 0, 0, 1);
    chk("s2", {pc_out, instr_out}, {32'd12, word(32'd8)});

    // Memory wait of 3 cycles on address 8
    cyc(0, 1, 32'h0, 0);
    cyc(0, 0, 0, 1);
    cyc(0, 0, 0, 1);
    s0 = stall_cnt;
    for (int i = 0; i < 3; i++) cyc(0, 0, 0, 0);
    chk("wait_bubble", {pc_out, instr_out, 31'd0, valid_out}, 96'd0);
    chk("wait_stall3", 64'(stall_cnt), 64'(s0 + 16'd3));
    cyc(0, 0, 0, 1);
    chk("wait_done", {pc_out, instr_out}, {32'd12, word(32'd8)});

    // Freeze holds {8,w4} for two cycles
    cyc(0, 1, 32'h0, 1);
    cyc(0, 0, 0, 1);
    cyc(0, 0, 0, 1);
    cyc(1, 0, 0, 1);
    cyc(1, 0, 0, 1);
    chk("frz_hold", {pc_out, instr_out}, {32'd8, word(32'd4)});
    cyc(0, 0, 0, 1);
    chk("frz_next", {pc_out, instr_out}, {32'd12, word(32'd8)});

    // Branch with freeze and rdy both high squashes the held instruction
    cyc(1, 1, 32'h100, 1);
    chk("br_clear", {pc_out, instr_out, 31'd0, valid_out}, 96'd0);
    cyc(0, 0, 0, 1);
    chk("br_target", {pc_out, instr_out}, {32'h104, word(32'h100)});

    // Randomised traffic
    for (int i = 0; i < 300; i++) begin
      cyc(logic'($urandom_range(0, 3) == 0), logic'($urandom_range(0, 15) == 0),
          $urandom & 32'hFFFF_FFFC, logic'($urandom_range(0, 3) != 0));
    end

    // PC wrap, then saturate the stall counter
    cyc(0, 1, 32'hFFFF_FFFC, 1);
    cyc(0, 0, 0, 1);
    chk("wrap_pc_out", 64'(pc_out), 64'd0);
    chk("wrap_valid", 64'(valid_out), 64'd1);
    for (int i = 0; i < 65540; i++) cyc(0, 0, 0, 0);
    chk("stall_sat", 64'(stall_cnt), 64'hFFFF);
    chk("sat_addr", 64'(bus.imem_addr), 64'd0);

    // Asynchronous reset mid-wait, away from any edge
    #2;
    rst = 0;
    model_reset();
    #1;
    chk("arst_req", 64'(bus.imem_req), 64'd0);
    chk("arst_out", {pc_out, instr_out, 31'd0, valid_out}, 96'd0);
    chk("arst_stall", 64'(stall_cnt), 64'd0);
    chk("arst_addr", 64'(bus.imem_addr), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/if_fetch_unit.md
Name: if_fetch_unit

Overview:
- Instruction-fetch producer for the IF/ID pipeline register.
- Holds the architectural PC, issues per-cycle requests to instruction memory and captures returned words.
- Presents {pc_out, instr_out} as the IF/ID register's PC_in / Instruction_IN inputs, honouring that register's freeze.
- Handles branch redirect from EXE and inserts zero bubbles when no instruction is available.

Parameters:
- ADDR_W, 32, PC / memory address width.
- DATA_W, 32, instruction word width.
- RESET_PC, 0, PC value loaded at reset.
- PC_STEP, 4, PC increment per fetched instruction.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous reset, active-low (asserted when 0).
- freeze  in  1  downstream IF/ID register holding; the current output is not consumed this cycle.
- branch_taken  in  1  redirect request from EXE.
- branch_addr  in  ADDR_W  redirect target.
- imem_req  out  1  fetch request this cycle.
- imem_addr  out  ADDR_W  fetch address; always equals pc.
- imem_rdy  in  1  memory returns imem_rdata this cycle.
- imem_rdata  in  DATA_W  fetched instruction.
- pc_out  out  ADDR_W  address of fetched instruction + PC_STEP; drives IF/ID PC_in.
- instr_out  out  DATA_W  fetched instruction; drives IF/ID Instruction_IN.
- valid_out  out  1  pc_out/instr_out hold a real instruction; 0 = bubble.
- stall_cnt  out  16  memory wait-cycle counter.

Behaviour:
- Reset (rst=0, async): pc=RESET_PC, state=BOOT, pc_out=0, instr_out=0, valid_out=0, stall_cnt=0. imem_req=0 while in reset.
- FSM:
  - BOOT: imem_req=0; unconditionally go to RUN at the next edge. Gives exactly one idle cycle after reset release.
  - RUN: steady state; no exit except reset.
- imem_req (combinational) = (state==RUN) & ~branch_taken & (~valid_out | ~freeze).
- Transfer occurs on an edge where imem_req & imem_rdy. Memory must tolerate imem_req dropping with no transfer; there is no stability requirement on the request.
- Edge update priority:
  1. branch_taken=1: pc<=branch_addr; pc_out<=0, instr_out<=0, valid_out<=0. This applies regardless of freeze, and the buffered instruction is squashed.
  2. Else transfer: instr_out<=imem_rdata, pc_out<=pc+PC_STEP, valid_out<=1, pc<=pc+PC_STEP.
  3. Else freeze=0: output consumed; pc_out<=0, instr_out<=0, valid_out<=0 (bubble).
  4. Else (freeze=1, no transfer): hold all outputs and pc.
- Latency: instruction visible on outputs the cycle after its transfer edge. With imem_rdy tied 1 and freeze=0, one instruction per cycle, no bubbles.
- Freeze with valid_out=1 suppresses imem_req, so a held instruction is never overwritten. Consumption and refill in the same edge are allowed when freeze=0.
- Arithmetic: pc+PC_STEP is modulo 2^ADDR_W; wrap from all-ones region to 0 is silent. branch_addr is used unaligned as given.
- stall_cnt: +1 on each edge with imem_req=1 & imem_rdy=0. Saturates at 16'hFFFF. Cleared only by reset.
- Reset asserted mid-wait: all state returns to reset values immediately, and any outstanding request is abandoned.

Test Plan:
- Reset release, imem_rdy=1, imem_rdata=addr-derived, freeze=0:
  - cycle 1 after release: imem_req=0;
  - then imem_addr=0,4,8;
  - outputs {pc_out,instr_out} = {4,w0},{8,w4},{12,w8} on consecutive cycles, valid_out=1.
- imem_rdy low 3 cycles on addr 8: stall_cnt +3; pc_out/instr_out=0/valid_out=0 bubbles during the wait; then {12,w8}.
- freeze=1 for 2 cycles while valid_out=1 with {8,w4}: imem_req=0, outputs held {8,w4}; after release the next edge loads {12,w8}.
- branch_taken=1, branch_addr=0x100, coinciding with imem_rdy=1 and freeze=1: outputs cleared to 0, valid_out=0, next imem_addr=0x100, then {0x104,w100}.
- pc=0xFFFFFFFC transfer: pc_out=0, next imem_addr=0; force 65540 wait cycles: stall_cnt=16'hFFFF, then async rst=0 mid-wait clears all outputs without a clock edge.
